// File: rtl/muldiv_hilo_if.sv
// Core-side request/read bundle for the HI/LO multiply/divide engine.
// Core drives through master; the engine sits on slave.
interface muldiv_hilo_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic            op_signed;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            rd_sel;
  logic [XLEN-1:0] rd_data;
  logic            busy;
  logic            done;
  logic            div_by_zero;

  modport master (
    output start, op, op_signed,
    output src_a, src_b, rd_sel,
    input  rd_data, busy, done,
    input  div_by_zero
  );

  modport slave (
    input  start, op, op_signed,
    input  src_a, src_b, rd_sel,
    output rd_data, busy, done,
    output div_by_zero
  );
endinterface

// File: rtl/muldiv_hilo.sv
// Sequential mult/div (34 cycles) with HI/LO pair, mthi/mtlo and read port.
// MULDIV_SIGNED_EN enables signed operands via op_signed.
module muldiv_hilo #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_hilo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  state_t            state;
  logic [4:0]        cnt;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic              is_div;
  logic              bz_q;
  logic              busy_q;
  logic              done_q;
  logic              dbz_q;

  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remd;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;

  assign bus.rd_data     = bus.rd_sel ? hi : lo;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

`ifdef MULDIV_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_a_q;
  logic neg_b_q;

  assign neg_a = bus.op_signed & bus.src_a[XLEN-1];
  assign neg_b = bus.op_signed & bus.src_b[XLEN-1];
  assign mag_a = neg_a ? -bus.src_a : bus.src_a;
  assign mag_b = neg_b ? -bus.src_b : bus.src_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (state == IDLE && bus.start
                 && !bus.op[1]) begin
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
    end
  end

  // Remainder follows the dividend's sign.
  always_comb begin
    prod = acc;
    quot = acc[XLEN-1:0];
    remd = rem[XLEN-1:0];
    if (neg_a_q ^ neg_b_q) begin
      prod = -acc;
      quot = -acc[XLEN-1:0];
    end
    if (neg_a_q) remd = -rem[XLEN-1:0];
  end
`else
  logic unused_sign;

  assign unused_sign = bus.op_signed;
  assign mag_a       = bus.src_a;
  assign mag_b       = bus.src_b;
  assign prod        = acc;
  assign quot        = acc[XLEN-1:0];
  assign remd        = rem[XLEN-1:0];
`endif

  assign fix_hi = bz_q   ? '0
                : is_div ? remd
                :          prod[2*XLEN-1:XLEN];
  assign fix_lo = bz_q   ? '0
                : is_div ? quot
                :          prod[XLEN-1:0];

  // Shift-add: upper half accumulates, multiplier drains from LSB.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                  + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring step; quotient bits shift into the dividend slot.
  assign div_shift = {rem[XLEN-1:0], acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_ge    = rem[XLEN] | (div_shift >= {1'b0, opnd});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
      is_div <= 1'b0;
      bz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            unique case (bus.op)
              OP_MTHI: hi <= bus.src_a;
              OP_MTLO: lo <= bus.src_a;
              default: begin
                is_div <= bus.op[0];
                bz_q   <= bus.op[0]
                          && bus.src_b == '0;
                opnd   <= bus.op[0] ? mag_b : mag_a;
                acc    <= {{XLEN{1'b0}},
                           (bus.op[0] ? mag_a : mag_b)};
                rem    <= '0;
                cnt    <= 5'(XLEN - 1);
                busy_q <= 1'b1;
                dbz_q  <= 1'b0;
                state  <= RUN;
              end
            endcase
          end
        end
        RUN: begin
          if (is_div) begin
            rem <= div_ge ? div_diff : div_shift;
            acc[XLEN-1:0] <= {acc[XLEN-2:0], div_ge};
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          hi     <= fix_hi;
          lo     <= fix_lo;
          dbz_q  <= bz_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
